// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shift/rotate unit. A start pulse in IDLE latches the operand F,
// the mode H and the distance amount. The operand is then shifted one bit
// position per clock. Completion is flagged with a one-cycle done pulse, and
// the result is held in S until the next operation completes.
//
// Build option:
//   SEQ_SHIFTER_BARREL_EN - when defined, the full-distance result is computed
//                           combinationally on the start edge and DONE is
//                           entered directly (latency of 1 edge for every mode).
//                           When undefined, the unit iterates one bit per clock.
//
// Parameters:
//   N      operand width (N >= 2)
//   SW     amount width, derived as $clog2(N)
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   request, sampled only in IDLE
//   H       in   3-bit mode code
//   amount  in   shift distance, 0..N-1
//   F       in   operand
//   S       out  result register
//   busy    out  high while in SHIFT or DONE
//   done    out  one-cycle pulse when S is valid and new
//
// Mode codes (H):
//   000 pass            100 pass
//   001 logical left    101 rotate left
//   010 logical right   110 rotate right
//   011 clear           111 arithmetic right
// -----------------------------------------------------------------------------
module seq_shifter #(
   parameter  int N  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [2:0]    H,
   input  logic [SW-1:0] amount,
   input  logic [N-1:0]  F,
   output logic [N-1:0]  S,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   localparam logic [SW-1:0] C_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] C_ONE  = SW'(1);

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  w_q,     w_d;
   logic [2:0]    mode_q,  mode_d;
   logic [SW-1:0] c_q,     c_d;
   logic [N-1:0]  s_q,     s_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   // One-bit step of the selected shift/rotate; non-shift modes leave w alone.
   function automatic logic [N-1:0] shift_one(input logic [N-1:0] w,
                                              input logic [2:0]   mode);
      logic [N-1:0] r;
      case (mode)
         3'b001:  r = {w[N-2:0], 1'b0};
         3'b010:  r = {1'b0, w[N-1:1]};
         3'b101:  r = {w[N-2:0], w[N-1]};
         3'b110:  r = {w[0], w[N-1:1]};
         3'b111:  r = {w[N-1], w[N-1:1]};
         default: r = w;
      endcase
      return r;
   endfunction

   // True for the modes that actually move bits.
   function automatic logic is_shift_mode(input logic [2:0] mode);
      logic r;
      case (mode)
         3'b001, 3'b010, 3'b101, 3'b110, 3'b111: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   // Result for modes that need no iteration: clear gives zero, else pass.
   function automatic logic [N-1:0] direct_result(input logic [N-1:0] f,
                                                  input logic [2:0]   mode);
      logic [N-1:0] r;
      if (mode == 3'b011) begin
         r = {N{1'b0}};
      end else begin
         r = f;
      end
      return r;
   endfunction

`ifdef SEQ_SHIFTER_BARREL_EN
   // Full-distance result: the same one-bit step unrolled amt times, so the
   // barrel build is bit-exact with the iterative build.
   function automatic logic [N-1:0] barrel_result(input logic [N-1:0]  f,
                                                  input logic [2:0]    mode,
                                                  input logic [SW-1:0] amt);
      logic [N-1:0] r;
      if (is_shift_mode(mode)) begin
         r = f;
         for (int i = 0; i < N - 1; i++) begin
            if (i < int'(amt)) begin
               r = shift_one(r, mode);
            end else begin
               r = r;
            end
         end
      end else begin
         r = direct_result(f, mode);
      end
      return r;
   endfunction
`endif

   // Next-state logic for the IDLE/SHIFT/DONE sequencer and the datapath.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      mode_d  = mode_q;
      c_d     = c_q;
      s_d     = s_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               w_d    = F;
               mode_d = H;
               c_d    = amount;
`ifdef SEQ_SHIFTER_BARREL_EN
               s_d     = barrel_result(F, H, amount);
               state_d = ST_DONE;
`else
               if (is_shift_mode(H) && (amount != C_ZERO)) begin
                  state_d = ST_SHIFT;
               end else begin
                  // Zero distance behaves like pass for shift modes.
                  s_d     = direct_result(F, H);
                  state_d = ST_DONE;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         // Not reachable in the barrel build: IDLE always goes to DONE.
         ST_SHIFT: begin
            w_d = shift_one(w_q, mode_q);
            c_d = c_q - C_ONE;
            if (c_q == C_ONE) begin
               s_d     = w_d;
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Flags are registered from the next state so they line up with it.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         w_q     <= {N{1'b0}};
         mode_q  <= 3'b000;
         c_q     <= C_ZERO;
         s_q     <= {N{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         mode_q  <= mode_d;
         c_q     <= c_d;
         s_q     <= s_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign S    = s_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
